rtc_bus_seq: RTL and testbench

- Parametrised bus-transaction sequencer for the external RTC's multiplexed address/data bus (a_d, cs, rd, wr). Successor to the fixed per-register write controller.
- Accepts a generic burst command: read or write, start address, length, auto-increment on/off. Generates the address/data phase timing with configurable setup, strobe, hold and gap widths.
- Sits between the clock/date/timer control FSMs, which issue commands, and the RTC pins.

---
 rtl/rtc_bus_pkg.sv | 44 ++++
 rtl/rtc_phase_timer.sv | 30 +++
 rtl/rtc_bus_seq.sv | 204 ++++++++++++++++++++
 tb/tb_rtc_bus_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencer and the clock/date/timer
// control FSMs that issue commands to it.
//   - DATA_W         : default bus/data width
//   - T_*_DEF        : default phase timing (cycles)
//   - TIMER_W        : width of the phase down-counter (timing parameters must fit)
//   - seq_state_t    : sequencer state encoding, ST_* constants
package rtc_bus_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned T_SETUP_DEF  = 1;
  localparam int unsigned T_STROBE_DEF = 2;
  localparam int unsigned T_HOLD_DEF   = 1;
  localparam int unsigned T_GAP_DEF    = 1;
  localparam int unsigned TIMER_W      = 8;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t ST_IDLE     = 4'd0;
  localparam seq_state_t ST_A_SETUP  = 4'd1;
  localparam seq_state_t ST_A_STROBE = 4'd2;
  localparam seq_state_t ST_A_HOLD   = 4'd3;
  localparam seq_state_t ST_A_GAP    = 4'd4;
  localparam seq_state_t ST_W_WAIT   = 4'd5;
  localparam seq_state_t ST_D_SETUP  = 4'd6;
  localparam seq_state_t ST_D_STROBE = 4'd7;
  localparam seq_state_t ST_D_HOLD   = 4'd8;
  localparam seq_state_t ST_D_GAP    = 4'd9;
  localparam seq_state_t ST_FIN      = 4'd10;

  function automatic logic is_addr_state(seq_state_t s);
    return (s == ST_A_SETUP) || (s == ST_A_STROBE) || (s == ST_A_HOLD) || (s == ST_A_GAP);
  endfunction

  function automatic logic is_data_state(seq_state_t s);
    return (s == ST_D_SETUP) || (s == ST_D_STROBE) || (s == ST_D_HOLD) || (s == ST_D_GAP);
  endfunction

  // States during which cs_n is driven low (GAP states release the chip select).
  function automatic logic is_select_state(seq_state_t s);
    return (s == ST_A_SETUP) || (s == ST_A_STROBE) || (s == ST_A_HOLD) ||
           (s == ST_D_SETUP) || (s == ST_D_STROBE) || (s == ST_D_HOLD);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase.
//   clk, reset : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase length minus one
//   tc         : terminal count, high on the last cycle of the phase
module rtc_phase_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/rtc_bus_seq.sv
// Burst bus-transaction sequencer for the external RTC multiplexed address/data bus.
// Each beat is an address phase (a_d=0) followed by a data phase (a_d=1); each phase is
// SETUP/STROBE/HOLD/GAP with parameterised widths. Write bursts wait for write data
// (W_WAIT) before each data phase.
//   command  : req_valid/req_ready, req_wr, req_inc, req_addr, req_len
//   wdata    : wdata/wdata_valid/wdata_ready write-data handshake
//   rdata    : rdata with one-cycle rdata_valid per read beat
//   status   : busy (accept..done), done (one-cycle pulse at FIN)
//   RTC pins : a_d, cs_n, rd_n, wr_n, ad_out, ad_oe, ad_in
// All outputs are registered copies of the next-state decode, so they line up with the
// state the FSM is in.
module rtc_bus_seq #(
  parameter int unsigned DATA_W    = rtc_bus_pkg::DATA_W,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned T_SETUP   = rtc_bus_pkg::T_SETUP_DEF,
  parameter int unsigned T_STROBE  = rtc_bus_pkg::T_STROBE_DEF,
  parameter int unsigned T_HOLD    = rtc_bus_pkg::T_HOLD_DEF,
  parameter int unsigned T_GAP     = rtc_bus_pkg::T_GAP_DEF,
  localparam int unsigned LEN_W    = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_inc,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              busy,
  output logic              a_d,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in
);

  import rtc_bus_pkg::*;

  localparam int unsigned TW = rtc_bus_pkg::TIMER_W;

  seq_state_t        state_q, state_d;
  logic              wr_q, wr_d;
  logic              inc_q, inc_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_tc;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    inc_d   = inc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          inc_d   = req_inc;
          addr_d  = req_addr;
          rem_d   = (req_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : req_len;
          state_d = (req_len == '0) ? ST_FIN : ST_A_SETUP;
        end
      end
      ST_A_SETUP:  if (tmr_tc) state_d = ST_A_STROBE;
      ST_A_STROBE: if (tmr_tc) state_d = ST_A_HOLD;
      ST_A_HOLD:   if (tmr_tc) state_d = ST_A_GAP;
      ST_A_GAP:    if (tmr_tc) state_d = wr_q ? ST_W_WAIT : ST_D_SETUP;
      ST_W_WAIT: begin
        if (wdata_valid) begin
          data_d  = wdata;
          state_d = ST_D_SETUP;
        end
      end
      ST_D_SETUP:  if (tmr_tc) state_d = ST_D_STROBE;
      ST_D_STROBE: if (tmr_tc) state_d = ST_D_HOLD;
      ST_D_HOLD:   if (tmr_tc) state_d = ST_D_GAP;
      ST_D_GAP: begin
        if (tmr_tc) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_d == '0) begin
            state_d = ST_FIN;
          end else begin
            // Wraps modulo 2^DATA_W.
            addr_d  = addr_q + DATA_W'(inc_q);
            state_d = ST_A_SETUP;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reload the phase timer whenever a new state is entered; timed states never
  // transition to themselves, so a state change marks the start of a phase.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_A_SETUP, ST_D_SETUP:   tmr_val = TW'(T_SETUP - 1);
      ST_A_STROBE, ST_D_STROBE: tmr_val = TW'(T_STROBE - 1);
      ST_A_HOLD, ST_D_HOLD:     tmr_val = TW'(T_HOLD - 1);
      ST_A_GAP, ST_D_GAP:       tmr_val = TW'(T_GAP - 1);
      default:                  tmr_val = '0;
    endcase
  end

  rtc_phase_timer #(
    .WIDTH(TW)
  ) u_phase_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tc      (tmr_tc)
  );

  // ---------------------------------------------------------------------------
  // Output decode from the next state, registered below
  // ---------------------------------------------------------------------------
  logic              a_phase_d, d_phase_d;
  logic              cs_n_d, rd_n_d, wr_n_d, a_d_d, ad_oe_d;
  logic [DATA_W-1:0] ad_out_d;
  logic              busy_d, done_d, req_ready_d, wdata_ready_d;
  logic              sample_rd;

  always_comb begin
    a_phase_d     = is_addr_state(state_d);
    d_phase_d     = is_data_state(state_d);
    cs_n_d        = !is_select_state(state_d);
    wr_n_d        = !((state_d == ST_A_STROBE) || ((state_d == ST_D_STROBE) && wr_d));
    rd_n_d        = !((state_d == ST_D_STROBE) && !wr_d);
    a_d_d         = !a_phase_d;
    ad_oe_d       = a_phase_d || (d_phase_d && wr_d);
    ad_out_d      = a_phase_d ? addr_d : ((d_phase_d && wr_d) ? data_d : '0);
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_FIN);
    done_d        = (state_d == ST_FIN);
    req_ready_d   = (state_d == ST_IDLE);
    wdata_ready_d = (state_d == ST_W_WAIT);
  end

  // Read data is captured on the last rd_n-low cycle.
  assign sample_rd = (state_q == ST_D_STROBE) && tmr_tc && !wr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      inc_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rem_q       <= '0;
      cs_n        <= 1'b1;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      a_d         <= 1'b1;
      ad_oe       <= 1'b0;
      ad_out      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      req_ready   <= 1'b1;
      wdata_ready <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      inc_q       <= inc_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      cs_n        <= cs_n_d;
      rd_n        <= rd_n_d;
      wr_n        <= wr_n_d;
      a_d         <= a_d_d;
      ad_oe       <= ad_oe_d;
      ad_out      <= ad_out_d;
      rdata_valid <= sample_rd;
      if (sample_rd) begin
        rdata <= ad_in;
      end
      done        <= done_d;
      busy        <= busy_d;
      req_ready   <= req_ready_d;
      wdata_ready <= wdata_ready_d;
    end
  end

endmodule

// File: tb/tb_rtc_bus_seq.sv
module tb_rtc_bus_seq;

  localparam int DW       = 8;
  localparam int MAXB     = 16;
  localparam int LEN_W    = $clog2(MAXB + 1);
  localparam int T_STROBE = 2;
  // Default timing: each phase is 1+2+1+1 = 5 cycles; a write beat adds one W_WAIT cycle.
  localparam int BEAT_W   = 11;
  localparam int BEAT_R   = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0, req_ready, req_wr = 1'b0, req_inc = 1'b0;
  logic [DW-1:0]    req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic [DW-1:0]    wdata = '0;
  logic             wdata_valid = 1'b0, wdata_ready;
  logic [DW-1:0]    rdata;
  logic             rdata_valid, done, busy, a_d, cs_n, rd_n, wr_n, ad_oe;
  logic [DW-1:0]    ad_out;
  logic [DW-1:0]    ad_in = '0;

  rtc_bus_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_inc    (req_inc),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .wdata      (wdata),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .done       (done),
    .busy       (busy),
    .a_d        (a_d),
    .cs_n       (cs_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .ad_out     (ad_out),
    .ad_oe      (ad_oe),
    .ad_in      (ad_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: expected {a_d, ad_out} per wr_n strobe, expected rdata per pulse.
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] rd_exp_q[$];
  logic [DW-1:0] wq[$];

  int cyc = 0, done_cyc = 0, done_cnt = 0, acc_cyc = 0;
  int cs_low_cnt = 0, addr_strobes = 0;
  bit rd_cmd = 0;

  always @(posedge clk) cyc++;

  // Write-data source: offers the head of wq whenever it is non-empty.
  bit pend_pop = 0;
  always @(negedge clk) begin
    if (pend_pop && wq.size() > 0) void'(wq.pop_front());
    if (wq.size() > 0) begin
      wdata       = wq[0];
      wdata_valid = 1'b1;
    end else begin
      wdata_valid = 1'b0;
    end
    pend_pop = wdata_valid && wdata_ready && reset;
  end

  // Bus monitor.
  logic prev_wr_n = 1'b1, prev_rd_n = 1'b1;
  int   wr_len = 0, rd_len = 0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_wr_n = 1'b1;
      prev_rd_n = 1'b1;
      wr_len    = 0;
      rd_len    = 0;
    end else begin
      if (!cs_n) cs_low_cnt++;
      if (!wr_n) begin
        if (prev_wr_n) begin
          check("strobe_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            check("bus_a_d", int'(a_d), int'(e[DW]));
            check("bus_ad_out", int'(ad_out), int'(e[DW-1:0]));
            check("bus_oe_wr", int'(ad_oe), 1);
          end
          if (!a_d) addr_strobes++;
          wr_len = 1;
        end else begin
          wr_len++;
        end
      end else if (!prev_wr_n) begin
        check("wr_n_width", wr_len, T_STROBE);
      end
      if (!rd_n) begin
        rd_len = prev_rd_n ? 1 : rd_len + 1;
        check("rd_a_d", int'(a_d), 1);
      end else if (!prev_rd_n) begin
        check("rd_n_width", rd_len, T_STROBE);
      end
      if (rd_cmd && busy && a_d) check("read_oe_off", int'(ad_oe), 0);
      if (rdata_valid) begin
        check("rdata_expected", int'(rd_exp_q.size() != 0), 1);
        if (rd_exp_q.size() != 0) check("rdata", int'(rdata), int'(rd_exp_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_drop_at_done", int'(busy), 0);
      end
      prev_wr_n = wr_n;
      prev_rd_n = rd_n;
    end
  end

  task automatic push_beat(input logic [DW-1:0] a, input logic [DW-1:0] d, input bit is_wr);
    exp_q.push_back({1'b0, a});
    if (is_wr) begin
      exp_q.push_back({1'b1, d});
      wq.push_back(d);
    end
  endtask

  task automatic issue(input bit wr, input bit inc, input logic [DW-1:0] addr,
                       input int len);
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_inc   = inc;
    req_addr  = addr;
    req_len   = LEN_W'(len);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    check("accepted", int'(req_ready), 0);
  endtask

  // Cycles counted from the accept cycle (1 = the cycle right after it).
  task automatic wait_done(input string tag, input int exp_cycles);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, int'(done_cnt != start), 1);
    check({tag, "_latency"}, done_cyc - acc_cyc + 1, exp_cycles);
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_idle"}, int'(req_ready), 1);
    check({tag, "_bus_sb_empty"}, exp_q.size(), 0);
    check({tag, "_rd_sb_empty"}, rd_exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int n;

    #1 reset = 1'b0;
    #2;
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_rd_n", int'(rd_n), 1);
    check("rst_wr_n", int'(wr_n), 1);
    check("rst_a_d", int'(a_d), 1);
    check("rst_ad_oe", int'(ad_oe), 0);
    check("rst_ad_out", int'(ad_out), 0);
    check("rst_rdata", int'(rdata), 0);
    check("rst_rdata_valid", int'(rdata_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_req_ready", int'(req_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Write burst with increment.
    push_beat(8'h21, 8'h45, 1);
    push_beat(8'h22, 8'h30, 1);
    push_beat(8'h23, 8'h12, 1);
    issue(1, 1, 8'h21, 3);
    check("wr3_busy", int'(busy), 1);
    wait_done("wr3", 1 + 3 * BEAT_W);

    // Single read.
    ad_in  = 8'h59;
    rd_cmd = 1;
    push_beat(8'h41, 8'h00, 0);
    rd_exp_q.push_back(8'h59);
    issue(0, 1, 8'h41, 1);
    wait_done("rd1", 1 + BEAT_R);
    rd_cmd = 0;
    ad_in  = 8'h00;

    // Address wrap with and without increment.
    push_beat(8'hFF, 8'h11, 1);
    push_beat(8'h00, 8'h22, 1);
    issue(1, 1, 8'hFF, 2);
    wait_done("wrap_inc", 1 + 2 * BEAT_W);
    push_beat(8'hFF, 8'h33, 1);
    push_beat(8'hFF, 8'h44, 1);
    issue(1, 0, 8'hFF, 2);
    wait_done("wrap_fixed", 1 + 2 * BEAT_W);

    // Write-data underflow before beat 2; a stray request meanwhile must be ignored.
    push_beat(8'h10, 8'hA1, 1);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'hB2});
    issue(1, 1, 8'h10, 2);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(wdata_ready && wq.size() == 0) && n < 200);
    check("uf_stall_reached", int'(n < 200), 1);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_len   = LEN_W'(1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      check("uf_ready", int'(wdata_ready), 1);
      check("uf_cs_n", int'(cs_n), 1);
      check("uf_ad_oe", int'(ad_oe), 0);
      check("uf_req_ready", int'(req_ready), 0);
    end
    req_valid = 1'b0;
    wq.push_back(8'hB2);
    wait_done("underflow", 1 + 2 * BEAT_W + 7);

    // Zero-length command: no bus activity, done the next cycle.
    base = cs_low_cnt;
    issue(1, 1, 8'h55, 0);
    wait_done("len0", 1);
    check("len0_no_cs", cs_low_cnt - base, 0);

    // Over-length command clamps to MAX_BURST beats.
    for (int i = 0; i < MAXB; i++) push_beat(DW'(i), DW'(8'hC0 + i), 1);
    issue(1, 1, 8'h00, 20);
    wait_done("len20", 1 + MAXB * BEAT_W);

    // Reset during the address strobe of beat 2.
    base = addr_strobes;
    push_beat(8'h30, 8'h01, 1);
    push_beat(8'h31, 8'h02, 1);
    push_beat(8'h32, 8'h03, 1);
    issue(1, 1, 8'h30, 3);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(addr_strobes - base == 2 && !wr_n) && n < 200);
    check("rst_mid_reached", int'(n < 200), 1);
    reset = 1'b0;
    #1;
    check("rst_mid_cs_n", int'(cs_n), 1);
    check("rst_mid_wr_n", int'(wr_n), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ad_oe", int'(ad_oe), 0);
    check("rst_mid_a_d", int'(a_d), 1);
    exp_q.delete();
    wq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    push_beat(8'h5A, 8'h3C, 1);
    issue(1, 1, 8'h5A, 1);
    wait_done("post_rst", 1 + BEAT_W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
